// File: rtl/fast_ctrl_pkg.sv
// Shared state encoding, default parameters and width helpers
// for the multi-unit fixed-point extraction controller.
package fast_ctrl_pkg;

    localparam int DEF_N_SAMPLES = 128;
    localparam int DEF_MUL_LAT   = 3;
    localparam int DEF_N_UNITS   = 4;
    localparam int DEF_MAX_ITER  = 64;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LOAD_B = 4'd1,
        ST_MUL    = 4'd2,
        ST_MEAN   = 4'd3,
        ST_SUB    = 4'd4,
        ST_DECOR  = 4'd5,
        ST_NORM   = 4'd6,
        ST_CHECK  = 4'd7,
        ST_DONE   = 4'd8
    } fast_state_e;

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/fast_stage_counter.sv
// Per-state cycle counter: cleared on state entry, counts while
// enabled, flags when the current count equals the stage length.
module fast_stage_counter #(
    parameter int W = 8
) (
    input  logic         clk_fast,
    input  logic         rst_fast,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk_fast or posedge rst_fast) begin
        if (rst_fast) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == last);

endmodule

// File: rtl/multi_unit_fast_controller.sv
// Sequencer for sequential multi-unit fixed-point extraction:
// drives datapath stage enables and tracks unit/iteration/timeouts.
module multi_unit_fast_controller
    import fast_ctrl_pkg::*;
#(
    parameter int N_SAMPLES = DEF_N_SAMPLES,
    parameter int MUL_LAT   = DEF_MUL_LAT,
    parameter int N_UNITS   = DEF_N_UNITS,
    parameter int MAX_ITER  = DEF_MAX_ITER
) (
    input  logic                             clk_fast,
    input  logic                             rst_fast,
    input  logic                             start,
    input  logic                             abort,
    input  logic                             conv_valid,
    input  logic                             converged,
    output logic                             fast_busy,
    output logic                             en_b,
    output logic                             en_mul,
    output logic                             en_mean,
    output logic                             en_sub,
    output logic                             en_decor,
    output logic                             en_norm,
    output logic [clog2_min1(N_UNITS)-1:0]   unit_idx,
    output logic [clog2_min1(N_UNITS)-1:0]   decor_sel,
    output logic [clog2_min1(MAX_ITER)-1:0]  iter_cnt,
    output logic                             done,
    output logic [N_UNITS-1:0]               timeout_mask
);

    localparam int UW = clog2_min1(N_UNITS);
    localparam int IW = clog2_min1(MAX_ITER);
    localparam int CW = clog2_min1(max3(N_SAMPLES, MUL_LAT, N_UNITS));

    localparam logic [UW-1:0] LAST_UNIT = UW'(N_UNITS - 1);
    localparam logic [IW-1:0] LAST_ITER = IW'(MAX_ITER - 1);

    fast_state_e        state, state_n;
    logic [UW-1:0]      unit_n;
    logic [IW-1:0]      iter_n;
    logic [N_UNITS-1:0] mask_n;

    logic          stage_load, stage_en, stage_tc;
    logic [CW-1:0] stage_last, stage_cnt;

    always_ff @(posedge clk_fast or posedge rst_fast) begin
        if (rst_fast) begin
            state        <= ST_IDLE;
            unit_idx     <= '0;
            iter_cnt     <= '0;
            timeout_mask <= '0;
        end else begin
            state        <= state_n;
            unit_idx     <= unit_n;
            iter_cnt     <= iter_n;
            timeout_mask <= mask_n;
        end
    end

    always_comb begin
        state_n    = state;
        unit_n     = unit_idx;
        iter_n     = iter_cnt;
        mask_n     = timeout_mask;
        stage_en   = 1'b0;
        stage_last = '0;
        fast_busy  = (state != ST_IDLE);
        en_b       = 1'b0;
        en_mul     = 1'b0;
        en_mean    = 1'b0;
        en_sub     = 1'b0;
        en_decor   = 1'b0;
        en_norm    = 1'b0;
        decor_sel  = '0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_n = ST_LOAD_B;
                    unit_n  = '0;
                    iter_n  = '0;
                    mask_n  = '0;
                end
            end
            ST_LOAD_B: begin
                en_b    = 1'b1;
                state_n = ST_MUL;
            end
            ST_MUL: begin
                en_mul     = 1'b1;
                stage_en   = 1'b1;
                stage_last = CW'(MUL_LAT - 1);
                if (stage_tc) state_n = ST_MEAN;
            end
            ST_MEAN: begin
                en_mul     = 1'b1;
                en_mean    = 1'b1;
                stage_en   = 1'b1;
                stage_last = CW'(N_SAMPLES - 1);
                if (stage_tc) state_n = ST_SUB;
            end
            ST_SUB: begin
                en_sub  = 1'b1;
                state_n = (unit_idx != '0) ? ST_DECOR : ST_NORM;
            end
            ST_DECOR: begin
                // one cycle per earlier unit, selected by the stage count
                en_decor   = 1'b1;
                stage_en   = 1'b1;
                stage_last = CW'(unit_idx) - 1'b1;
                decor_sel  = UW'(stage_cnt);
                if (stage_tc) state_n = ST_NORM;
            end
            ST_NORM: begin
                en_norm = 1'b1;
                state_n = ST_CHECK;
            end
            ST_CHECK: begin
                if (conv_valid) begin
                    if (converged || iter_cnt == LAST_ITER) begin
                        if (!converged) mask_n[unit_idx] = 1'b1;
                        if (unit_idx == LAST_UNIT) begin
                            state_n = ST_DONE;
                        end else begin
                            unit_n  = unit_idx + 1'b1;
                            iter_n  = '0;
                            state_n = ST_LOAD_B;
                        end
                    end else begin
                        iter_n  = iter_cnt + 1'b1;
                        state_n = ST_LOAD_B;
                    end
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                unit_n  = '0;
                iter_n  = '0;
                state_n = ST_IDLE;
            end
            default: begin
                state_n = ST_IDLE;
                unit_n  = '0;
                iter_n  = '0;
            end
        endcase
        // abort wins over every transition; the timeout record survives
        if (abort) begin
            state_n = ST_IDLE;
            unit_n  = '0;
            iter_n  = '0;
            mask_n  = timeout_mask;
        end
    end

    assign stage_load = (state_n != state);

    fast_stage_counter #(
        .W (CW)
    ) u_stage_counter (
        .clk_fast (clk_fast),
        .rst_fast (rst_fast),
        .load     (stage_load),
        .enable   (stage_en),
        .last     (stage_last),
        .cnt      (stage_cnt),
        .tc       (stage_tc)
    );

endmodule

// File: tb/tb_multi_unit_fast_controller.sv
// Bench for multi_unit_fast_controller: expected-output table per
// scenario fed into a scoreboard and matched cycle by cycle.
module tb_multi_unit_fast_controller;

    localparam int NS = 8;
    localparam int ML = 3;
    localparam int NU = 2;
    localparam int MI = 4;

    logic       clk_fast = 1'b0;
    logic       rst_fast = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       conv_valid = 1'b0;
    logic       converged = 1'b0;
    logic       fast_busy, en_b, en_mul, en_mean, en_sub, en_decor, en_norm;
    logic [0:0] unit_idx, decor_sel;
    logic [1:0] iter_cnt;
    logic       done;
    logic [1:0] timeout_mask;
    logic [13:0] obs_v;

    typedef struct {
        int          scn;
        int          cyc;
        string       name;
        logic [13:0] exp;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int checks = 0;
    int failures = 0;

    multi_unit_fast_controller #(
        .N_SAMPLES (NS),
        .MUL_LAT   (ML),
        .N_UNITS   (NU),
        .MAX_ITER  (MI)
    ) dut (
        .clk_fast     (clk_fast),
        .rst_fast     (rst_fast),
        .start        (start),
        .abort        (abort),
        .conv_valid   (conv_valid),
        .converged    (converged),
        .fast_busy    (fast_busy),
        .en_b         (en_b),
        .en_mul       (en_mul),
        .en_mean      (en_mean),
        .en_sub       (en_sub),
        .en_decor     (en_decor),
        .en_norm      (en_norm),
        .unit_idx     (unit_idx),
        .decor_sel    (decor_sel),
        .iter_cnt     (iter_cnt),
        .done         (done),
        .timeout_mask (timeout_mask)
    );

    always #5 clk_fast = ~clk_fast;

    assign obs_v = {fast_busy, en_b, en_mul, en_mean, en_sub, en_decor,
                    en_norm, unit_idx, decor_sel, iter_cnt, done,
                    timeout_mask};

    // st: 0 IDLE 1 LOAD_B 2 MUL 3 MEAN 4 SUB 5 DECOR 6 NORM 7 CHECK 8 DONE
    function automatic logic [13:0] expv(int st, logic u, logic [1:0] it,
                                         logic [1:0] m);
        logic [5:0] en;
        case (st)
            1:       en = 6'b100000;
            2:       en = 6'b010000;
            3:       en = 6'b011000;
            4:       en = 6'b000100;
            5:       en = 6'b000010;
            6:       en = 6'b000001;
            default: en = 6'b000000;
        endcase
        return {st != 0, en, u, 1'b0, it, st == 8, m};
    endfunction

    task automatic add(int s, int c, string nm, int st, logic u,
                       logic [1:0] it, logic [1:0] m);
        vec_t v;
        v.scn  = s;
        v.cyc  = c;
        v.name = nm;
        v.exp  = expv(st, u, it, m);
        vecs.push_back(v);
    endtask

    task automatic check(string nm, logic [13:0] got, logic [13:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", nm, got, exp);
        end
    endtask

    task automatic check_int(string nm, int got, int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // {start, abort, conv_valid, converged} for cycle k of scenario s
    function automatic logic [3:0] stim(int s, int k);
        case (s)
            1: return {k == 0, 1'b0, 1'b1, 1'b1};
            2: return {k == 0, 1'b0, 1'b1, k >= 61};
            3: return {k == 0, 1'b0, !(k >= 15 && k < 20), 1'b1};
            4: return {k == 0 || k == 12, k == 10, 1'b1, 1'b1};
            5: return {k == 0 || k == 3 || k == 20 || k == 32,
                       1'b0, 1'b1, 1'b1};
            default: return 4'b0000;
        endcase
    endfunction

    task automatic run_scn(int s, int n);
        int dn_cnt;
        int dc_cnt;
        vec_t r;
        dn_cnt = 0;
        dc_cnt = 0;
        sb.delete();
        foreach (vecs[i]) if (vecs[i].scn == s) sb.push_back(vecs[i]);
        for (int k = 0; k < n; k++) begin
            {start, abort, conv_valid, converged} = stim(s, k);
            dn_cnt += int'(done);
            dc_cnt += int'(en_decor);
            while (sb.size() > 0 && sb[0].cyc == k) begin
                r = sb.pop_front();
                check($sformatf("s%0d_c%0d_%s", s, k, r.name), obs_v, r.exp);
            end
            @(posedge clk_fast);
            #1;
        end
        {start, abort, conv_valid, converged} = 4'b0000;
        while (sb.size() > 0) begin
            r = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL s%0d_c%0d_%s never sampled", s, r.cyc, r.name);
        end
        check_int($sformatf("s%0d_done_pulses", s), dn_cnt, 1);
        check_int($sformatf("s%0d_decor_cycles", s), dc_cnt, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // scenario 1: both units converge immediately
        add(1, 0,  "idle",     0, 0, 0, 0);
        add(1, 1,  "load_b",   1, 0, 0, 0);
        add(1, 2,  "mul_first",2, 0, 0, 0);
        add(1, 4,  "mul_last", 2, 0, 0, 0);
        add(1, 5,  "mean_first",3, 0, 0, 0);
        add(1, 12, "mean_last",3, 0, 0, 0);
        add(1, 13, "sub_u0",   4, 0, 0, 0);
        add(1, 14, "norm_u0",  6, 0, 0, 0);
        add(1, 15, "check_u0", 7, 0, 0, 0);
        add(1, 16, "load_u1",  1, 1, 0, 0);
        add(1, 28, "sub_u1",   4, 1, 0, 0);
        add(1, 29, "decor_u1", 5, 1, 0, 0);
        add(1, 30, "norm_u1",  6, 1, 0, 0);
        add(1, 31, "check_u1", 7, 1, 0, 0);
        add(1, 32, "done",     8, 1, 0, 0);
        add(1, 33, "idle_end", 0, 0, 0, 0);
        // scenario 2: unit 0 never converges and times out
        add(2, 15, "chk_i0",   7, 0, 0, 0);
        add(2, 16, "lb_i1",    1, 0, 1, 0);
        add(2, 30, "chk_i1",   7, 0, 1, 0);
        add(2, 45, "chk_i2",   7, 0, 2, 0);
        add(2, 46, "lb_i3",    1, 0, 3, 0);
        add(2, 60, "chk_i3",   7, 0, 3, 0);
        add(2, 61, "lb_u1",    1, 1, 0, 1);
        add(2, 74, "decor_u1", 5, 1, 0, 1);
        add(2, 77, "done",     8, 1, 0, 1);
        add(2, 78, "idle_mask",0, 0, 0, 1);
        // scenario 3: conv_valid late by 5 cycles on unit 0
        add(3, 15, "chk_wait0",7, 0, 0, 0);
        add(3, 17, "chk_wait2",7, 0, 0, 0);
        add(3, 19, "chk_wait4",7, 0, 0, 0);
        add(3, 20, "chk_valid",7, 0, 0, 0);
        add(3, 21, "lb_u1",    1, 1, 0, 0);
        add(3, 34, "decor_u1", 5, 1, 0, 0);
        add(3, 36, "check_u1", 7, 1, 0, 0);
        add(3, 37, "done",     8, 1, 0, 0);
        add(3, 38, "idle_end", 0, 0, 0, 0);
        // scenario 4: abort in MEAN, then a fresh full run
        add(4, 10, "mean",     3, 0, 0, 0);
        add(4, 11, "aborted",  0, 0, 0, 0);
        add(4, 12, "idle",     0, 0, 0, 0);
        add(4, 13, "lb_rerun", 1, 0, 0, 0);
        add(4, 27, "check_u0", 7, 0, 0, 0);
        add(4, 41, "decor_u1", 5, 1, 0, 0);
        add(4, 43, "check_u1", 7, 1, 0, 0);
        add(4, 44, "done",     8, 1, 0, 0);
        add(4, 45, "idle_end", 0, 0, 0, 0);
        // scenario 5: extra starts while busy and in DONE are ignored
        add(5, 1,  "load_b",   1, 0, 0, 0);
        add(5, 3,  "mul_mid",  2, 0, 0, 0);
        add(5, 4,  "mul_last", 2, 0, 0, 0);
        add(5, 5,  "mean",     3, 0, 0, 0);
        add(5, 15, "check_u0", 7, 0, 0, 0);
        add(5, 21, "mean_u1",  3, 1, 0, 0);
        add(5, 32, "done",     8, 1, 0, 0);
        add(5, 33, "idle",     0, 0, 0, 0);
        add(5, 34, "idle_hold",0, 0, 0, 0);

        start = 1'b1;
        #2;
        check("reset_outputs", obs_v, 14'd0);
        @(posedge clk_fast);
        #1;
        check("reset_ignores_start", obs_v, 14'd0);
        rst_fast = 1'b0;
        start = 1'b0;
        @(posedge clk_fast);
        #1;

        run_scn(1, 35);
        run_scn(2, 80);

        check("mask_held_idle", obs_v, expv(0, 0, 0, 2'b01));
        #2 rst_fast = 1'b1;
        #1 check("rst_async_idle", obs_v, 14'd0);
        rst_fast = 1'b0;
        @(posedge clk_fast);
        #1;

        run_scn(3, 40);
        run_scn(4, 48);
        run_scn(5, 36);

        start = 1'b1;
        @(posedge clk_fast);
        #1;
        start = 1'b0;
        repeat (7) begin
            @(posedge clk_fast);
            #1;
        end
        check("pre_rst_mean", obs_v, expv(3, 0, 0, 0));
        #2 rst_fast = 1'b1;
        #1 check("rst_async_mean", obs_v, 14'd0);
        @(posedge clk_fast);
        #1;
        check("rst_hold", obs_v, 14'd0);
        rst_fast = 1'b0;
        @(posedge clk_fast);
        #1;
        run_scn(1, 35);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
